// File: rtl/alu_serial_rx.sv
// -----------------------------------------------------------------------------
// alu_serial_rx
//
// Serial-input deserializer feeding the ALU execute stage. The one-bit `sin`
// stream carries 11-bit frames (start=0, type, d[7]..d[0] MSB first, stop=1).
// Eight DATA frames followed by one CMD frame form a transaction. The result
// is presented as parallel operands with a valid/ready handshake.
//
// Parameters
//   IDLE_BITS  consecutive high samples needed after a stop-bit error
//              before start-bit detection re-arms (>= 1)
//
// Ports
//   clk        clock, all sampling on the rising edge
//   rst        asynchronous active-high reset
//   sin        serial input, idle high, one bit per clock
//   out_ready  consumer accepts the transaction when high with out_valid
//   out_valid  transaction available, held until accepted
//   A          operand A (data bytes 5..8)
//   B          operand B (data bytes 1..4)
//   ctl        data byte of the CMD frame
//   err_data   qualified by out_valid: DATA frame count was not 8
//   err_frame  one-cycle pulse on a stop-bit error
//   overrun    one-cycle pulse when a completed transaction is dropped
// -----------------------------------------------------------------------------
module alu_serial_rx #(
   parameter int IDLE_BITS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [7:0]  ctl,
   output logic        err_data,
   output logic        err_frame,
   output logic        overrun
);

   localparam int IW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TYPE   = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_RESYNC = 3'd4
   } state_t;

   state_t        state_q, state_d;

   logic [2:0]    bit_cnt_q;
   logic          is_cmd_q;
   logic [7:0]    byte_q;
   logic [63:0]   shift_q;
   logic [3:0]    byte_cnt_q;
   logic [IW-1:0] idle_cnt_q;

   logic          out_valid_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [7:0]    ctl_q;
   logic          err_data_q;
   logic          err_frame_q;
   logic          overrun_q;

   // Strobes decoded from the FSM for the datapath
   logic          commit_data;
   logic          commit_cmd;
   logic          frame_bad;
   logic          hold_blocked;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!sin) state_d = S_TYPE;
         S_TYPE:   state_d = S_DATA;
         S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_STOP;
         S_STOP:   state_d = sin ? S_IDLE : S_RESYNC;
         S_RESYNC: if (sin && (idle_cnt_q == IW'(IDLE_BITS - 1))) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------------- outputs
   always_comb begin
      commit_data = 1'b0;
      commit_cmd  = 1'b0;
      frame_bad   = 1'b0;
      if (state_q == S_STOP) begin
         commit_data = sin && !is_cmd_q;
         commit_cmd  = sin &&  is_cmd_q;
         frame_bad   = !sin;
      end
   end

   // A held result that is not being accepted on this edge cannot be replaced.
   assign hold_blocked = out_valid_q && !out_ready;

   // ------------------------------------------------------------ frame capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         is_cmd_q   <= 1'b0;
         byte_q     <= '0;
         idle_cnt_q <= '0;
      end else begin
         // Counter wraps 7 -> 0 on the last data bit, so it is ready for the
         // next frame without an explicit clear.
         bit_cnt_q <= (state_q == S_DATA) ? bit_cnt_q + 3'd1 : 3'd0;

         if (state_q == S_TYPE) begin
            is_cmd_q <= sin;
         end

         if (state_q == S_DATA) begin
            byte_q <= {byte_q[6:0], sin};
         end

         // Any low sample in RESYNC restarts the run of high samples.
         if (state_q == S_RESYNC && sin) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
         end else begin
            idle_cnt_q <= '0;
         end
      end
   end

   // ----------------------------------------------------- transaction assembly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end else if (commit_data) begin
         shift_q    <= {shift_q[55:0], byte_q};
         byte_cnt_q <= (byte_cnt_q == 4'd9) ? 4'd9 : byte_cnt_q + 4'd1;
      end else if (commit_cmd || frame_bad) begin
         // Operand state is cleared even when the result itself is dropped.
         shift_q    <= '0;
         byte_cnt_q <= '0;
      end
   end

   // ------------------------------------------------------ result + handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         ctl_q       <= '0;
         err_data_q  <= 1'b0;
         err_frame_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         err_frame_q <= frame_bad;
         overrun_q   <= commit_cmd && hold_blocked;

         if (commit_cmd && !hold_blocked) begin
            // Covers the simultaneous accept-and-load case: valid stays high.
            out_valid_q <= 1'b1;
            ctl_q       <= byte_q;
            if (byte_cnt_q == 4'd8) begin
               b_q        <= shift_q[63:32];
               a_q        <= shift_q[31:0];
               err_data_q <= 1'b0;
            end else begin
               b_q        <= '0;
               a_q        <= '0;
               err_data_q <= 1'b1;
            end
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign A         = a_q;
   assign B         = b_q;
   assign ctl       = ctl_q;
   assign err_data  = err_data_q;
   assign err_frame = err_frame_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_rx
//
// Scoreboard bench for alu_serial_rx. The driver sends whole frames; a
// frame-level reference model (a queue of received bytes plus a "result
// held" flag) predicts each transaction, err_frame pulse and overrun pulse
// and pushes them, stamped with the edge at which they must appear. A
// separate monitor on the falling edge compares the DUT against the queues.
// -----------------------------------------------------------------------------
module tb_alu_serial_rx;

   localparam int IDLE_BITS = 2;

   localparam int C_NONE = 0;
   localparam int C_DATA = 1;
   localparam int C_CMD  = 2;
   localparam int C_ERR  = 3;

   logic        clk;
   logic        rst;
   logic        sin;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] A;
   logic [31:0] B;
   logic [7:0]  ctl;
   logic        err_data;
   logic        err_frame;
   logic        overrun;

   alu_serial_rx #(.IDLE_BITS(IDLE_BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .A         (A),
      .B         (B),
      .ctl       (ctl),
      .err_data  (err_data),
      .err_frame (err_frame),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  c;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned ef_q[$];
   int unsigned ov_q[$];

   // Reference model state
   logic [7:0]  m_bytes[$];
   bit          m_valid = 0;
   int          ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
   bit          force_ready = 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // One bit time: choose out_ready, advance the model for the coming edge,
   // drive the bit, then wait past the edge.
   task automatic step(input logic b, input int code, input logic [7:0] d);
      exp_t        x;
      int unsigned e;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (force_ready) out_ready = 1'b1;
      force_ready = 0;
      e = cyc + 1;

      if (code == C_DATA) begin
         m_bytes.push_back(d);
      end else if (code == C_ERR) begin
         m_bytes.delete();
         ef_q.push_back(e);
      end

      if (code == C_CMD) begin
         if (m_valid && !out_ready) begin
            ov_q.push_back(e);
         end else begin
            x.cyc = e;
            x.c   = d;
            if (m_bytes.size() == 8) begin
               x.b   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               x.a   = {m_bytes[4], m_bytes[5], m_bytes[6], m_bytes[7]};
               x.err = 1'b0;
            end else begin
               x.b   = '0;
               x.a   = '0;
               x.err = 1'b1;
            end
            exp_q.push_back(x);
            m_valid = 1;
         end
         m_bytes.delete();
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end

      sin = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, C_NONE, 8'h00);
   endtask

   task automatic send_frame(input bit is_cmd, input logic [7:0] d, input bit bad, input bit rdy_stop);
      step(1'b0, C_NONE, 8'h00);
      step(is_cmd, C_NONE, 8'h00);
      for (int i = 7; i >= 0; i--) step(d[i], C_NONE, 8'h00);
      if (rdy_stop) force_ready = 1;
      step(!bad, bad ? C_ERR : (is_cmd ? C_CMD : C_DATA), d);
   endtask

   task automatic send_txn(input logic [63:0] data, input int nd, input logic [7:0] cmd, input bit rdy_stop);
      for (int i = 0; i < nd; i++) send_frame(1'b0, data[63-8*i -: 8], 1'b0, 1'b0);
      send_frame(1'b1, cmd, 1'b0, rdy_stop);
   endtask

   task automatic model_reset();
      exp_q.delete();
      ef_q.delete();
      ov_q.delete();
      m_bytes.delete();
      m_valid = 0;
   endtask

   // ------------------------------------------------------------------ monitor
   always @(negedge clk) begin
      if (!rst) begin
         bit exp_v;
         bit exp_ef;
         bit exp_ov;
         exp_v = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
         chk("out_valid", 128'(out_valid), 128'(exp_v));
         if (exp_v && out_valid) begin
            chk("result", {A, B, ctl, err_data},
                {exp_q[0].a, exp_q[0].b, exp_q[0].c, exp_q[0].err});
            if (out_ready) begin
               $display("txn accepted cyc=%0d A=%08h B=%08h ctl=%02h err_data=%0b",
                        cyc, A, B, ctl, err_data);
               void'(exp_q.pop_front());
            end
         end
         exp_ef = (ef_q.size() > 0) && (ef_q[0] == cyc);
         chk("err_frame", 128'(err_frame), 128'(exp_ef));
         if (exp_ef) void'(ef_q.pop_front());
         exp_ov = (ov_q.size() > 0) && (ov_q[0] == cyc);
         chk("overrun", 128'(overrun), 128'(exp_ov));
         if (exp_ov) void'(ov_q.pop_front());
      end
   end

   // ------------------------------------------------------------------- driver
   initial begin
      rst       = 1'b1;
      sin       = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 128'({out_valid, A, B, ctl, err_data, err_frame, overrun}), 128'(0));
      rst = 1'b0;
      idle(3);

      // Normal transaction
      ready_mode = 0;
      send_txn(64'h01020304_0A0B0C0D, 8, 8'h81, 1'b0);
      idle(3);

      // Short operand, then a clean full transaction
      send_txn(64'h11223344_00000000, 4, 8'h81, 1'b0);
      send_txn(64'hDEADBEEF_CAFEF00D, 8, 8'h42, 1'b0);
      idle(2);

      // Stop-bit error on DATA byte 3, recovery, clean transaction
      send_frame(1'b0, 8'hA1, 1'b0, 1'b0);
      send_frame(1'b0, 8'hA2, 1'b0, 1'b0);
      send_frame(1'b0, 8'hA3, 1'b1, 1'b0);
      idle(IDLE_BITS);
      send_txn(64'h55AA55AA_12345678, 8, 8'h07, 1'b0);
      idle(2);

      // Backpressure across two transactions -> overrun, then accept
      ready_mode = 1;
      send_txn(64'h10203040_50607080, 8, 8'hC1, 1'b0);
      send_txn(64'h99999999_88888888, 8, 8'hC2, 1'b0);
      idle(3);
      ready_mode = 0;
      idle(3);

      // Accept exactly on the second CMD stop edge
      ready_mode = 1;
      send_txn(64'h0F0E0D0C_0B0A0908, 8, 8'hE1, 1'b0);
      send_txn(64'h76543210_FEDCBA98, 8, 8'hE2, 1'b1);
      idle(2);
      ready_mode = 0;
      idle(3);

      // Reset during DATA byte 6 bit 3 while a result is held
      ready_mode = 1;
      send_txn(64'h13579BDF_2468ACE0, 8, 8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) send_frame(1'b0, 8'hF0 + 8'(i), 1'b0, 1'b0);
      step(1'b0, C_NONE, 8'h00);
      step(1'b0, C_NONE, 8'h00);
      for (int i = 7; i >= 3; i--) step(1'b1, C_NONE, 8'h00);
      rst = 1'b1;
      #1;
      chk("reset_midframe", 128'({out_valid, A, B, ctl, err_data, err_frame, overrun}), 128'(0));
      model_reset();
      sin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ready_mode = 0;
      idle(2);
      send_txn(64'hAABBCCDD_EEFF0011, 8, 8'h5A, 1'b0);
      idle(2);

      // Randomised traffic
      for (int t = 0; t < 30; t++) begin
         int nd;
         ready_mode = 2;
         nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 8;
         for (int i = 0; i <= nd; i++) begin
            bit bad;
            bad = ($urandom_range(0, 19) == 0);
            send_frame(i == nd, 8'($urandom), bad, 1'b0);
            if (bad) idle(IDLE_BITS + int'($urandom_range(0, 2)));
            else     idle(int'($urandom_range(0, 2)));
         end
      end

      // Drain
      ready_mode = 0;
      idle(5);
      chk("results_drained", 128'(exp_q.size()), 128'(0));
      chk("err_frame_drained", 128'(ef_q.size()), 128'(0));
      chk("overrun_drained", 128'(ov_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
